spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI register controller: decodes a command byte from an SPI slave and then
// streams reads or writes across an 8-entry register map (ID, six R/W, error count).
//
// state | meaning
// IDLE  | no frame; ID byte preloaded into the slave for the command phase
// CMD   | waiting for the command byte (bit7 read, bits[6:0] start address)
// WRITE | each received byte is written at addr and echoed back
// READ  | each received dummy byte is answered with reg[addr]
// ERR   | bad address; answer 8'hFF until the frame ends
module spi_reg_ctrl #(
  parameter logic [7:0] ID_VALUE = 8'h5A
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_SPI_CS_n,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  output logic        o_Wr_Pulse,
  output logic [2:0]  o_Wr_Addr,
  output logic [7:0]  o_Wr_Data,
  output logic [47:0] o_Regs,
  output logic        o_Busy
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;

  state_t      state;
  logic        cs_meta;
  logic        cs_s;
  logic        id_pending;
  logic [2:0]  addr;
  logic [47:0] regs_q;
  logic [7:0]  err_cnt;

  function automatic logic [7:0] reg_rd(input logic [2:0] a, input logic [47:0] r,
                                        input logic [7:0] e);
    case (a)
      3'd0:    reg_rd = ID_VALUE;
      3'd7:    reg_rd = e;
      default: reg_rd = r[{a - 3'd1, 3'b000} +: 8];
    endcase
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      cs_meta <= i_SPI_CS_n;
      cs_s    <= cs_meta;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      id_pending <= 1'b1;
      addr       <= 3'd0;
      regs_q     <= 48'h0;
      err_cnt    <= 8'h00;
      o_TX_DV    <= 1'b0;
      o_TX_Byte  <= 8'h00;
      o_Wr_Pulse <= 1'b0;
      o_Wr_Addr  <= 3'd0;
      o_Wr_Data  <= 8'h00;
      o_Busy     <= 1'b0;
    end else begin
      o_TX_DV    <= 1'b0;
      o_Wr_Pulse <= 1'b0;
      if (state != IDLE && cs_s) begin
        // CS release wins over a coincident byte; the ID is reloaded for the next frame
        state     <= IDLE;
        o_Busy    <= 1'b0;
        addr      <= 3'd0;
        o_TX_DV   <= 1'b1;
        o_TX_Byte <= ID_VALUE;
      end else begin
        unique case (state)
          IDLE: begin
            // only needed after reset; aborts load the ID on their own transition
            if (id_pending) begin
              id_pending <= 1'b0;
              o_TX_DV    <= 1'b1;
              o_TX_Byte  <= ID_VALUE;
            end
            if (!cs_s) begin
              state  <= CMD;
              o_Busy <= 1'b1;
            end
          end
          CMD: begin
            if (i_RX_DV) begin
              o_TX_DV <= 1'b1;
              if (i_RX_Byte[6:3] != 4'd0) begin
                state     <= ERR;
                o_TX_Byte <= 8'hFF;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              end else if (i_RX_Byte[7]) begin
                state     <= READ;
                o_TX_Byte <= reg_rd(i_RX_Byte[2:0], regs_q, err_cnt);
                addr      <= i_RX_Byte[2:0] + 3'd1;
              end else begin
                state     <= WRITE;
                o_TX_Byte <= 8'h00;
                addr      <= i_RX_Byte[2:0];
              end
            end
          end
          WRITE: begin
            if (i_RX_DV) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= i_RX_Byte;
              addr      <= addr + 3'd1;
              if (addr != 3'd0 && addr != 3'd7) begin
                regs_q[{addr - 3'd1, 3'b000} +: 8] <= i_RX_Byte;
                o_Wr_Pulse <= 1'b1;
                o_Wr_Addr  <= addr;
                o_Wr_Data  <= i_RX_Byte;
              end
            end
          end
          READ: begin
            if (i_RX_DV) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= reg_rd(addr, regs_q, err_cnt);
              addr      <= addr + 3'd1;
            end
          end
          ERR: begin
            if (i_RX_DV) begin
              o_TX_DV   <= 1'b1;
              o_TX_Byte <= 8'hFF;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_Regs = regs_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed SPI frames push expected TX bytes
// and writes into queues; a monitor pops and compares on every DUT pulse.
module tb_spi_reg_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_SPI_CS_n = 1'b1;
  logic        i_RX_DV = 1'b0;
  logic [7:0]  i_RX_Byte = 8'h00;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        o_Wr_Pulse;
  logic [2:0]  o_Wr_Addr;
  logic [7:0]  o_Wr_Data;
  logic [47:0] o_Regs;
  logic        o_Busy;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx[$];
  logic [10:0] exp_wr[$];

  spi_reg_ctrl dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_SPI_CS_n(i_SPI_CS_n),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .o_Wr_Pulse(o_Wr_Pulse), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
    .o_Regs(o_Regs), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: every TX or write pulse must match the oldest queued expectation
  initial begin
    logic [7:0]  etx;
    logic [10:0] ewr;
    forever begin
      @(negedge i_Clk);
      if (o_TX_DV === 1'b1) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx actual=%0h expected=none", o_TX_Byte);
        end else begin
          etx = exp_tx.pop_front();
          check("tx_byte", o_TX_Byte, etx);
        end
      end
      if (o_Wr_Pulse === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr actual=%0h expected=none", {o_Wr_Addr, o_Wr_Data});
        end else begin
          ewr = exp_wr.pop_front();
          check("wr_addr_data", {o_Wr_Addr, o_Wr_Data}, ewr);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // one byte from the slave; the answer must appear exactly one cycle later
  task automatic send(input logic [7:0] b, input logic [7:0] exp_b);
    exp_tx.push_back(exp_b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    tick(1);
    i_RX_DV = 1'b0;
    check("tx_latency", o_TX_DV, 1'b1);
    tick(1);
  endtask

  task automatic cs_low();
    i_SPI_CS_n = 1'b0;
    tick(4);
    check("busy_in_frame", o_Busy, 1'b1);
  endtask

  task automatic cs_high();
    exp_tx.push_back(8'h5A);
    i_SPI_CS_n = 1'b1;
    tick(5);
    check("busy_after_frame", o_Busy, 1'b0);
  endtask

  initial begin
    // reset release: one ID pulse, registers clear
    exp_tx.push_back(8'h5A);
    tick(2);
    i_Rst_L = 1'b1;
    tick(3);
    check("reset_regs", o_Regs, 48'h0);
    check("reset_busy", o_Busy, 1'b0);
    check("reset_id_seen", exp_tx.size(), 0);

    // a stray byte in IDLE is ignored
    i_RX_DV = 1'b1; i_RX_Byte = 8'h81; tick(1); i_RX_DV = 1'b0; tick(2);

    // write frame at reg2
    cs_low();
    send(8'h02, 8'h00);
    exp_wr.push_back({3'd2, 8'h11}); send(8'h11, 8'h11);
    exp_wr.push_back({3'd3, 8'h22}); send(8'h22, 8'h22);
    cs_high();
    check("regs_after_write", o_Regs, 48'h00_00_00_22_11_00);

    // read back from reg2
    cs_low();
    send(8'h82, 8'h11);
    send(8'h00, 8'h22);
    send(8'h00, 8'h00);
    cs_high();

    // write at reg6: addr 7 and wrapped addr 0 are dropped but still echoed
    cs_low();
    send(8'h06, 8'h00);
    exp_wr.push_back({3'd6, 8'hAA}); send(8'hAA, 8'hAA);
    send(8'hBB, 8'hBB);
    send(8'hCC, 8'hCC);
    cs_high();
    check("regs_after_wrap_write", o_Regs, 48'hAA_00_00_22_11_00);

    // read from reg7 wrapping through ID and reg1
    cs_low();
    send(8'h87, 8'h00);
    send(8'h00, 8'h5A);
    send(8'h00, 8'h00);
    send(8'h00, 8'h11);
    cs_high();

    // bad address: ERR answers FF and never writes
    cs_low();
    send(8'h0A, 8'hFF);
    send(8'h55, 8'hFF);
    cs_high();
    check("regs_after_err", o_Regs, 48'hAA_00_00_22_11_00);
    cs_low();
    send(8'h87, 8'h01);
    cs_high();

    // error counter saturates
    for (int i = 0; i < 300; i++) begin
      cs_low();
      send(8'h0A, 8'hFF);
      cs_high();
    end
    cs_low();
    send(8'h87, 8'hFF);
    cs_high();

    // CS abort mid-write, with a byte landing on the abort cycle
    cs_low();
    send(8'h01, 8'h00);
    exp_wr.push_back({3'd1, 8'h33}); send(8'h33, 8'h33);
    exp_tx.push_back(8'h5A);
    i_SPI_CS_n = 1'b1;
    tick(2);
    i_RX_DV = 1'b1; i_RX_Byte = 8'h77;
    tick(1);
    i_RX_DV = 1'b0;
    check("abort_busy", o_Busy, 1'b0);
    tick(4);
    check("regs_after_abort", o_Regs, 48'hAA_00_00_22_11_33);

    // reset mid-frame, coincident with a data byte
    cs_low();
    send(8'h03, 8'h00);
    i_Rst_L = 1'b0;
    i_RX_DV = 1'b1; i_RX_Byte = 8'h44;
    tick(1);
    i_RX_DV = 1'b0;
    check("midreset_busy", o_Busy, 1'b0);
    check("midreset_regs", o_Regs, 48'h0);
    i_SPI_CS_n = 1'b1;
    exp_tx.push_back(8'h5A);
    tick(1);
    i_Rst_L = 1'b1;
    tick(4);
    check("midreset_id_seen", exp_tx.size(), 0);

    // fresh frame after reset; error count was cleared
    cs_low();
    send(8'h05, 8'h00);
    exp_wr.push_back({3'd5, 8'h66}); send(8'h66, 8'h66);
    cs_high();
    check("regs_after_reset_write", o_Regs, 48'h00_66_00_00_00_00);
    cs_low();
    send(8'h87, 8'h00);
    cs_high();

    tick(5);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
